// File: rtl/tiamc1_nvram_upload.sv
// tiamc1_nvram_upload
// Serves HPS upload byte reads from the core's battery-backed RAM. Halts the CPU
// while a session is active, tracks whether NVRAM holds unsaved writes, and asks
// the HPS for an autosave once writes have been quiet for AS_FRAMES frames.
module tiamc1_nvram_upload #(
   parameter int         ADDR_W    = 12,
   parameter int         NV_BYTES  = 2048,
   parameter int         RAM_LAT   = 1,
   parameter logic [7:0] UP_INDEX  = 8'd4,
   parameter int         AS_FRAMES = 120
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              ioctl_upload,
   input  logic              ioctl_rd,
   input  logic [24:0]       ioctl_addr,
   input  logic [7:0]        ioctl_index,
   output logic [7:0]        ioctl_din,
   output logic              ioctl_upload_req,
   output logic              cpu_pause,
   input  logic              cpu_paused,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   input  logic [7:0]        mem_dout,
   input  logic              cpu_nv_wr,
   input  logic              vblank,
   input  logic              autosave_en,
   output logic              busy
);

   localparam int              FC_W     = $clog2(AS_FRAMES + 1);
   localparam logic [24:0]     NV_LIMIT = 25'(NV_BYTES);
   localparam logic [2:0]      LAT_LAST = 3'(RAM_LAT);
   localparam logic [FC_W-1:0] FC_MAX   = FC_W'(AS_FRAMES);

   typedef enum logic [1:0] {ST_IDLE, ST_HALT, ST_ARMED, ST_FETCH} state_t;

   state_t            state, state_nx;
   logic              sel;
   logic              pending;
   logic [24:0]       pend_addr;
   logic [24:0]       svc_addr;
   logic              in_range;
   logic              svc, issue, ff_rd, capture, latch_rd;
   logic [2:0]        lat_cnt;
   logic              reads_done, session_wr, session_ok;
   logic              dirty;
   logic              vblank_q, vb_rise;
   logic [FC_W-1:0]   frame_cnt;
   logic              as_done;

   assign sel     = ioctl_upload & (ioctl_index == UP_INDEX);
   assign busy    = (state != ST_IDLE);
   assign vb_rise = vblank & ~vblank_q;
   // A session ends cleanly only if the HPS actually read data and the CPU never
   // touched NVRAM while it was running; only then is the saved image current.
   assign session_ok = (state != ST_IDLE) & ~sel & reads_done & ~session_wr;

   // Next-state and per-cycle read strobes; a pending read takes priority over a new one.
   always_comb begin
      state_nx = state;
      svc      = 1'b0;
      issue    = 1'b0;
      ff_rd    = 1'b0;
      capture  = 1'b0;
      latch_rd = 1'b0;
      svc_addr = pending ? pend_addr : ioctl_addr;
      in_range = (svc_addr < NV_LIMIT);
      if (!sel) begin
         state_nx = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:  state_nx = ST_HALT;
            ST_HALT: begin
               latch_rd = ioctl_rd;
               if (cpu_paused) state_nx = ST_ARMED;
            end
            ST_ARMED: begin
               svc      = ioctl_rd | pending;
               latch_rd = ioctl_rd & pending;
               issue    = svc & in_range;
               ff_rd    = svc & ~in_range;
               if (issue) state_nx = ST_FETCH;
            end
            ST_FETCH: begin
               latch_rd = ioctl_rd;
               capture  = (lat_cnt == LAT_LAST);
               if (capture) state_nx = ST_ARMED;
            end
            default:  state_nx = ST_IDLE;
         endcase
      end
   end

   // FSM state, CPU halt request and the NVRAM read port.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state     <= ST_IDLE;
         cpu_pause <= 1'b0;
         mem_rd    <= 1'b0;
         mem_addr  <= '0;
         lat_cnt   <= '0;
      end else begin
         state     <= state_nx;
         cpu_pause <= (state_nx != ST_IDLE);
         mem_rd    <= issue;
         if (issue) mem_addr <= svc_addr[ADDR_W-1:0];
         lat_cnt   <= (state == ST_FETCH && !capture && sel) ? lat_cnt + 3'd1 : 3'd0;
      end
   end

   // One-deep pending read for strobes that arrive while halting or fetching.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         pending <= 1'b0;
      end else if (state_nx == ST_IDLE) begin
         pending <= 1'b0;
      end else if (latch_rd) begin
         pending <= 1'b1;
      end else if (svc) begin
         pending <= 1'b0;
      end
      if (latch_rd) pend_addr <= ioctl_addr;
   end

   // Read data back to the HPS; out-of-range addresses read as erased flash (FF).
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         ioctl_din <= 8'h00;
      end else if (capture) begin
         ioctl_din <= mem_dout;
      end else if (ff_rd) begin
         ioctl_din <= 8'hFF;
      end
   end

   // Per-session bookkeeping used to decide whether the upload cleared dirty.
   always_ff @(posedge clk_sys) begin
      if (reset || state == ST_IDLE) begin
         reads_done <= 1'b0;
         session_wr <= 1'b0;
      end else begin
         if (capture || ff_rd) reads_done <= 1'b1;
         if (cpu_nv_wr)        session_wr <= 1'b1;
      end
   end

   // Dirty flag: a CPU write always wins over a clean end of upload.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         dirty <= 1'b0;
      end else if (cpu_nv_wr) begin
         dirty <= 1'b1;
      end else if (session_ok) begin
         dirty <= 1'b0;
      end
   end

   // Quiet-frame counter and single-shot autosave request.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         vblank_q         <= 1'b0;
         frame_cnt        <= '0;
         as_done          <= 1'b0;
         ioctl_upload_req <= 1'b0;
      end else begin
         vblank_q         <= vblank;
         ioctl_upload_req <= 1'b0;
         if (cpu_nv_wr || session_ok) begin
            frame_cnt <= '0;
            as_done   <= 1'b0;
         end else begin
            if (vb_rise && dirty && frame_cnt != FC_MAX) frame_cnt <= frame_cnt + FC_W'(1);
            if (frame_cnt == FC_MAX && autosave_en && state == ST_IDLE && !as_done) begin
               ioctl_upload_req <= 1'b1;
               as_done          <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_tiamc1_nvram_upload.sv
// Directed bench for tiamc1_nvram_upload with a 1-cycle-latency NVRAM model.
module tb_tiamc1_nvram_upload;

   logic        clk_sys = 1'b0;
   logic        reset = 1'b1;
   logic        ioctl_upload = 1'b0;
   logic        ioctl_rd = 1'b0;
   logic [24:0] ioctl_addr = '0;
   logic [7:0]  ioctl_index = 8'd0;
   logic [7:0]  ioctl_din;
   logic        ioctl_upload_req;
   logic        cpu_pause;
   logic        cpu_paused = 1'b0;
   logic [11:0] mem_addr;
   logic        mem_rd;
   logic [7:0]  mem_dout = 8'h00;
   logic        cpu_nv_wr = 1'b0;
   logic        vblank = 1'b0;
   logic        autosave_en = 1'b0;
   logic        busy;

   int n_checks = 0;
   int n_errors = 0;
   int rd_cnt   = 0;
   int req_cnt  = 0;

   always #5 clk_sys = ~clk_sys;

   tiamc1_nvram_upload #(
      .ADDR_W(12), .NV_BYTES(2048), .RAM_LAT(1), .UP_INDEX(8'd4), .AS_FRAMES(120)
   ) dut (
      .clk_sys(clk_sys), .reset(reset), .ioctl_upload(ioctl_upload), .ioctl_rd(ioctl_rd),
      .ioctl_addr(ioctl_addr), .ioctl_index(ioctl_index), .ioctl_din(ioctl_din),
      .ioctl_upload_req(ioctl_upload_req), .cpu_pause(cpu_pause), .cpu_paused(cpu_paused),
      .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_dout(mem_dout), .cpu_nv_wr(cpu_nv_wr),
      .vblank(vblank), .autosave_en(autosave_en), .busy(busy)
   );

   function automatic logic [7:0] ram_byte(input logic [11:0] a);
      return a[7:0] ^ 8'h4A;
   endfunction

   // NVRAM model: data valid one clock after the read enable
   always @(posedge clk_sys) if (mem_rd) mem_dout <= ram_byte(mem_addr);

   // Count read enables and autosave pulses, sampled away from the active edge
   always @(negedge clk_sys) begin
      if (mem_rd) rd_cnt++;
      if (ioctl_upload_req) req_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk_sys);
   endtask

   task automatic do_rd(input logic [24:0] a);
      ioctl_addr = a;
      ioctl_rd   = 1'b1;
      tick();
      ioctl_rd   = 1'b0;
   endtask

   task automatic vb(input int n);
      repeat (n) begin
         vblank = 1'b1;
         tick(2);
         vblank = 1'b0;
         tick(2);
      end
   endtask

   task automatic nv_write();
      cpu_nv_wr = 1'b1;
      tick();
      cpu_nv_wr = 1'b0;
   endtask

   initial begin
      int r0;
      int bad;
      tick(3);
      check("rst_din",   32'(ioctl_din), 32'h00);
      check("rst_pause", 32'(cpu_pause), 32'h0);
      check("rst_mem_rd", 32'(mem_rd), 32'h0);
      check("rst_busy",  32'(busy), 32'h0);
      check("rst_req",   32'(ioctl_upload_req), 32'h0);
      check("rst_addr",  32'(mem_addr), 32'h0);
      reset = 1'b0;
      tick();

      // 1: basic in-range read, RAM_LAT=1
      ioctl_index  = 8'd4;
      ioctl_upload = 1'b1;
      tick();
      check("t1_pause_halt", 32'(cpu_pause), 32'h1);
      check("t1_busy", 32'(busy), 32'h1);
      tick(4);
      cpu_paused = 1'b1;
      tick();
      r0 = rd_cnt;
      do_rd(25'h010);
      check("t1_mem_rd", 32'(mem_rd), 32'h1);
      check("t1_mem_addr", 32'(mem_addr), 32'h010);
      tick();
      check("t1_mem_rd_1cyc", 32'(mem_rd), 32'h0);
      check("t1_din_early", 32'(ioctl_din), 32'h00);
      tick();
      check("t1_din", 32'(ioctl_din), 32'h5A);
      check("t1_pause_hold", 32'(cpu_pause), 32'h1);
      check("t1_rd_count", 32'(rd_cnt - r0), 32'd1);

      // 2: out-of-range and boundary addresses
      r0 = rd_cnt;
      do_rd(25'h800);
      check("t2_din_ff", 32'(ioctl_din), 32'hFF);
      tick();
      check("t2_no_rd", 32'(rd_cnt - r0), 32'd0);
      do_rd(25'h7FF);
      tick(2);
      check("t2_din_7ff", 32'(ioctl_din), 32'hB5);
      do_rd(25'h1000010);
      check("t2_noalias", 32'(ioctl_din), 32'hFF);
      tick(2);
      check("t2_rd_count", 32'(rd_cnt - r0), 32'd1);

      // read arriving while a fetch is in flight is queued and served after it
      r0 = rd_cnt;
      do_rd(25'h020);
      do_rd(25'h030);
      tick(5);
      check("t2_pend_din", 32'(ioctl_din), 32'h7A);
      check("t2_pend_count", 32'(rd_cnt - r0), 32'd2);

      ioctl_upload = 1'b0;
      cpu_paused   = 1'b0;
      tick();
      check("t2_close_pause", 32'(cpu_pause), 32'h0);
      check("t2_close_busy", 32'(busy), 32'h0);

      // 3: read strobe during HALT is held until the CPU is paused
      ioctl_upload = 1'b1;
      tick();
      r0 = rd_cnt;
      do_rd(25'h123);
      tick(2);
      cpu_paused = 1'b1;
      tick(6);
      check("t3_one_rd", 32'(rd_cnt - r0), 32'd1);
      check("t3_din", 32'(ioctl_din), 32'h69);
      ioctl_upload = 1'b0;
      cpu_paused   = 1'b0;
      tick(2);

      // 5: full upload of the 2048-byte image clears dirty
      nv_write();
      check("t5_dirty_set", 32'(dut.dirty), 32'h1);
      ioctl_upload = 1'b1;
      tick();
      cpu_paused = 1'b1;
      tick();
      bad = 0;
      for (int i = 0; i < 2048; i++) begin
         do_rd(25'(i));
         tick(2);
         if (ioctl_din !== ram_byte(12'(i))) bad++;
      end
      check("t5_bytes_bad", 32'(bad), 32'd0);
      ioctl_upload = 1'b0;
      cpu_paused   = 1'b0;
      tick();
      check("t5_pause", 32'(cpu_pause), 32'h0);
      check("t5_busy", 32'(busy), 32'h0);
      check("t5_dirty_clr", 32'(dut.dirty), 32'h0);

      // 4: autosave after 120 quiet frames; write at frame 60 restarts count
      autosave_en = 1'b1;
      r0 = req_cnt;
      nv_write();
      vb(60);
      nv_write();
      vb(119);
      tick(4);
      check("t4_no_early_req", 32'(req_cnt - r0), 32'd0);
      vb(1);
      tick(4);
      check("t4_req_pulse", 32'(req_cnt - r0), 32'd1);
      vb(10);
      check("t4_no_repeat", 32'(req_cnt - r0), 32'd1);

      // 6: reset during FETCH
      ioctl_upload = 1'b1;
      tick();
      cpu_paused = 1'b1;
      tick();
      do_rd(25'h010);
      reset        = 1'b1;
      ioctl_upload = 1'b0;
      cpu_paused   = 1'b0;
      tick();
      check("t6_pause", 32'(cpu_pause), 32'h0);
      check("t6_din", 32'(ioctl_din), 32'h00);
      check("t6_busy", 32'(busy), 32'h0);
      check("t6_mem_rd", 32'(mem_rd), 32'h0);
      reset = 1'b0;
      r0 = rd_cnt;
      tick(5);
      check("t6_no_stray_rd", 32'(rd_cnt - r0), 32'd0);
      check("t6_din_hold", 32'(ioctl_din), 32'h00);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
